alu_exec: RTL

Multi-cycle ALU execution stage directly downstream of the ALU control decoder: consumes the 4-bit ALU control code and two operands, produces a registered result plus a zero flag for branch resolution. Logic/arithmetic/compare ops complete in one cycle. Shifts use an iterative one-bit-per-cycle shifter to save area. Valid/ready handshakes on both sides let the pipeline stall around multi-cycle shifts.

---
 rtl/alu_exec_if.sv | 27 ++
 rtl/alu_exec.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - operand/result handshake bundle for the ALU execution stage
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    // Upstream decoder / downstream consumer side
    modport master (
        output in_valid, control, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // ALU execution stage side
    modport slave (
        input  in_valid, control, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - multi-cycle ALU stage: single-cycle logic/arith, bit-serial shifts
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_exec_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_SLL = 2'd0,
        DIR_SRL = 2'd1,
        DIR_SRA = 2'd2
    } shdir_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    shdir_t           shdir_q, shdir_d;

    logic [WIDTH-1:0] op_res;
    logic             op_shift;
    logic             op_illegal;
    shdir_t           op_dir;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] done_val;

    assign shamt = bus.b[SHW-1:0];

    // Decode the presented control code and compute every single-cycle result
    always_comb begin
        op_res     = '0;
        op_shift   = 1'b0;
        op_illegal = 1'b0;
        op_dir     = DIR_SLL;
        case (bus.control)
            OP_AND:  op_res = bus.a & bus.b;
            OP_OR:   op_res = bus.a | bus.b;
            OP_XOR:  op_res = bus.a ^ bus.b;
            OP_ADD:  op_res = bus.a + bus.b;
            OP_SUB:  op_res = bus.a - bus.b;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL: begin
                op_shift = 1'b1;
                op_dir   = DIR_SLL;
            end
            OP_SRL: begin
                op_shift = 1'b1;
                op_dir   = DIR_SRL;
            end
            OP_SRA: begin
                op_shift = 1'b1;
                op_dir   = DIR_SRA;
            end
            // Unlisted and unknown codes retire as a zero result flagged illegal
            default: op_illegal = 1'b1;
        endcase
    end

    // One-bit shift step; result_q doubles as the shift register while in SHIFT
    // (out_valid is low there, so nobody observes the intermediate values)
    always_comb begin
        step_val = result_q;
        case (shdir_q)
            DIR_SLL: step_val = {result_q[WIDTH-2:0], 1'b0};
            DIR_SRL: step_val = {1'b0, result_q[WIDTH-1:1]};
            DIR_SRA: step_val = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: step_val = result_q;
        endcase
    end

    // Value retired by a one-cycle op: zero-length shifts pass operand A through
    assign done_val = op_shift ? bus.a : op_res;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        shdir_d   = shdir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (op_shift && (shamt != '0)) begin
                        result_d  = bus.a;
                        cnt_d     = shamt;
                        shdir_d   = op_dir;
                        illegal_d = 1'b0;
                        state_d   = S_SHIFT;
                    end else begin
                        result_d  = done_val;
                        zero_d    = (done_val == '0);
                        illegal_d = op_illegal;
                        state_d   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                result_d = step_val;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    zero_d  = (step_val == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // New ops are only taken in IDLE, so a retire never overlaps an accept
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            shdir_q   <= DIR_SLL;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            shdir_q   <= shdir_d;
        end
    end

    // Handshake outputs come straight from the state register
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule
